// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (A) and load/store (B).
// sel/mem_req registered; acks pass straight through from mem_ack; a watchdog ends unacked accesses.
module mem_port_arbiter #(
  parameter int n  = 32,
  parameter int AW = 32,
  parameter int TO = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  input  logic          a_we,
  input  logic [n-1:0]  a_wdata,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [n-1:0]  b_wdata,
  output logic          a_ack,
  output logic          b_ack,
  output logic          err,
  output logic [n-1:0]  rdata,
  output logic          sel,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [n-1:0]  mem_wdata,
  input  logic          mem_ack,
  input  logic [n-1:0]  mem_rdata
);

  localparam int CW = $clog2(TO);
  localparam logic [CW-1:0] CNT_MAX = CW'(TO - 1);

  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

  state_t        state, state_n;
  logic          sel_n;
  logic          last, last_n;   // 0 = A granted last, 1 = B
  logic [CW-1:0] cnt, cnt_n;
  logic          cur_b;
  logic          other_req;

  assign cur_b     = (state == BUSY_B);
  assign other_req = cur_b ? a_req : b_req;

  always_comb begin
    state_n = state;
    sel_n   = sel;
    last_n  = last;
    cnt_n   = cnt;
    a_ack   = 1'b0;
    b_ack   = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE: begin
        if (a_req && (!b_req || last)) begin
          state_n = BUSY_A;
          sel_n   = 1'b0;
        end else if (b_req) begin
          state_n = BUSY_B;
          sel_n   = 1'b1;
        end
      end
      BUSY_A, BUSY_B: begin
        // A real ack in the timeout cycle takes precedence, so err only when mem_ack is absent.
        if (mem_ack || (cnt == CNT_MAX)) begin
          a_ack  = !cur_b;
          b_ack  = cur_b;
          err    = !mem_ack;
          last_n = cur_b;
          cnt_n  = '0;
          if (other_req) begin
            state_n = cur_b ? BUSY_A : BUSY_B;
            sel_n   = !cur_b;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      mem_req <= 1'b0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      last    <= last_n;
      cnt     <= cnt_n;
      mem_req <= (state_n != IDLE);
    end
  end

  assign mem_addr  = sel ? b_addr  : a_addr;
  assign mem_we    = sel ? b_we    : a_we;
  assign mem_wdata = sel ? b_wdata : a_wdata;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with TO=4: expected acks queued at stimulus, checked on ack.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [31:0] a_addr = '0, b_addr = '0;
  logic        a_we = 1'b0, b_we = 1'b0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic        a_ack, b_ack, err, sel, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter #(.n(32), .AW(32), .TO(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
    .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .err(err), .rdata(rdata),
    .sel(sel), .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        who;   // 0 = A, 1 = B
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  task automatic expect_ack(input logic who, input logic e, input logic c, input logic [31:0] d);
    exp_t x;
    x.who = who; x.err = e; x.chk = c; x.data = d;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (a_ack || b_ack) begin
      check_eq("ack_onehot", {31'b0, a_ack & b_ack}, 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_ack", {30'b0, b_ack, a_ack}, 32'd0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check_eq("ack_who", {31'b0, b_ack}, {31'b0, x.who});
        check_eq("ack_err", {31'b0, err}, {31'b0, x.err});
        if (x.chk) check_eq("ack_rdata", rdata, x.data);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values
    @(negedge clk);
    check_eq("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check_eq("rst_sel", {31'b0, sel}, 32'd0);
    check_eq("rst_acks", {29'b0, err, b_ack, a_ack}, 32'd0);
    nxt();
    rst_n = 1'b1;

    // Single read from A, acked in the 3rd BUSY cycle
    a_req = 1'b1; a_addr = 32'h0000_0040; a_we = 1'b0;
    @(negedge clk);
    check_eq("idle_mem_req", {31'b0, mem_req}, 32'd0);
    nxt();
    @(negedge clk);
    check_eq("rd_mem_req", {31'b0, mem_req}, 32'd1);
    check_eq("rd_sel", {31'b0, sel}, 32'd0);
    check_eq("rd_addr", mem_addr, 32'h0000_0040);
    check_eq("rd_we", {31'b0, mem_we}, 32'd0);
    nxt();
    nxt();
    mem_ack = 1'b1; mem_rdata = 32'h2009_0005; a_req = 1'b0;
    expect_ack(1'b0, 1'b0, 1'b1, 32'h2009_0005);
    nxt();
    mem_ack = 1'b0;
    @(negedge clk);
    check_eq("rd_done_idle", {31'b0, mem_req}, 32'd0);
    nxt();

    // Tie break after reset, then round-robin with both held
    do_reset();
    a_req = 1'b1; a_addr = 32'h0000_0100; a_we = 1'b0;
    b_req = 1'b1; b_addr = 32'h1001_0000; b_we = 1'b1; b_wdata = 32'hDEAD_BEEF;
    nxt();
    @(negedge clk);
    check_eq("tie_sel", {31'b0, sel}, 32'd0);
    check_eq("tie_mem_req", {31'b0, mem_req}, 32'd1);
    check_eq("tie_addr", mem_addr, 32'h0000_0100);
    nxt();
    mem_ack = 1'b1; mem_rdata = 32'h0000_00A0;
    expect_ack(1'b0, 1'b0, 1'b1, 32'h0000_00A0);
    @(negedge clk);
    check_eq("tie_b_ack", {31'b0, b_ack}, 32'd0);
    nxt();
    mem_ack = 1'b0;
    @(negedge clk);
    check_eq("sw_sel", {31'b0, sel}, 32'd1);
    check_eq("sw_mem_req", {31'b0, mem_req}, 32'd1);
    check_eq("sw_addr", mem_addr, 32'h1001_0000);
    check_eq("sw_we", {31'b0, mem_we}, 32'd1);
    check_eq("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    for (int i = 1; i <= 5; i++) begin
      logic g;
      g = (i % 2) == 1;
      @(negedge clk);
      check_eq($sformatf("rr%0d_sel", i), {31'b0, sel}, {31'b0, g});
      check_eq($sformatf("rr%0d_mem_req", i), {31'b0, mem_req}, 32'd1);
      nxt();
      mem_ack = 1'b1; mem_rdata = 32'h0000_1000 + i;
      expect_ack(g, 1'b0, !g, 32'h0000_1000 + i);
      if (i == 5) begin a_req = 1'b0; b_req = 1'b0; end
      nxt();
      mem_ack = 1'b0;
    end
    @(negedge clk);
    check_eq("rr_end_idle", {31'b0, mem_req}, 32'd0);

    // Timeout on B (TO=4), then ack in the 4th BUSY cycle
    do_reset();
    b_req = 1'b1; b_we = 1'b0;
    nxt();
    expect_ack(1'b1, 1'b1, 1'b0, 32'd0);
    nxt(); nxt(); nxt();
    b_req = 1'b0;
    @(negedge clk);
    check_eq("to_b_ack", {31'b0, b_ack}, 32'd1);
    check_eq("to_err", {31'b0, err}, 32'd1);
    nxt();
    @(negedge clk);
    check_eq("to_idle", {31'b0, mem_req}, 32'd0);
    b_req = 1'b1;
    nxt();
    nxt(); nxt(); nxt();
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D; b_req = 1'b0;
    expect_ack(1'b1, 1'b0, 1'b1, 32'h0BAD_F00D);
    @(negedge clk);
    check_eq("to_ack_err", {31'b0, err}, 32'd0);
    nxt();
    mem_ack = 1'b0;
    @(negedge clk);
    check_eq("to_ack_idle", {31'b0, mem_req}, 32'd0);

    // Reset in the 2nd BUSY_A cycle, with mem_ack high when it hits
    do_reset();
    a_req = 1'b1; a_addr = 32'h0000_0200;
    nxt();
    nxt();
    mem_ack = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_eq("mrst_mem_req", {31'b0, mem_req}, 32'd0);
    check_eq("mrst_sel", {31'b0, sel}, 32'd0);
    check_eq("mrst_a_ack", {31'b0, a_ack}, 32'd0);
    mem_ack = 1'b0;
    b_req = 1'b1;
    nxt();
    rst_n = 1'b1;
    nxt();
    @(negedge clk);
    check_eq("post_rst_sel", {31'b0, sel}, 32'd0);
    check_eq("post_rst_mem_req", {31'b0, mem_req}, 32'd1);
    nxt();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0A0A; a_req = 1'b0;
    expect_ack(1'b0, 1'b0, 1'b1, 32'h0000_0A0A);
    nxt();
    mem_ack = 1'b0;
    @(negedge clk);
    check_eq("post_rst_b_sel", {31'b0, sel}, 32'd1);
    nxt();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0B0B; b_req = 1'b0;
    expect_ack(1'b1, 1'b0, 1'b1, 32'h0000_0B0B);
    nxt();
    mem_ack = 1'b0;

    // Stray ack while idle
    nxt();
    mem_ack = 1'b1;
    @(negedge clk);
    check_eq("stray_acks", {30'b0, b_ack, a_ack}, 32'd0);
    check_eq("stray_mem_req", {31'b0, mem_req}, 32'd0);
    nxt();
    mem_ack = 1'b0;
    @(negedge clk);
    check_eq("stray_idle", {31'b0, mem_req}, 32'd0);
    check_eq("stray_sel", {31'b0, sel}, 32'd1);

    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
